// File: rtl/keypad_code_entry.sv
`default_nettype none
// ============================================================================
// keypad_code_entry : collects BCD keypresses into a packed code and submits
//                     it to the lock with a one-cycle strobe.
// Revision 1.0 - initial release
// ============================================================================
module keypad_code_entry #(
    parameter int          NUM_DIGITS     = 4,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [3:0]  KEY_CLEAR      = 4'hA,
    parameter logic [3:0]  KEY_ENTER      = 4'hB
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    entry_en,
    output logic [4*NUM_DIGITS-1:0] in_code,
    output logic                    code_valid,
    output logic [2:0]              digit_count,
    output logic                    entry_error,
    output logic                    timeout
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   entry_buf, entry_buf_next;
    logic [2:0]      count_next;
    logic [CW-1:0]   code_next;
    logic            code_valid_next, entry_error_next, timeout_next;
    logic [IW-1:0]   idle_cnt, idle_cnt_next;
    logic            key_accepted;
    logic            idle_expired;

    assign key_accepted = key_valid && entry_en;
    assign idle_expired = (state != IDLE) && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            entry_buf   <= '0;
            digit_count <= '0;
            in_code     <= '0;
            code_valid  <= 1'b0;
            entry_error <= 1'b0;
            timeout     <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_next;
            entry_buf   <= entry_buf_next;
            digit_count <= count_next;
            in_code     <= code_next;
            code_valid  <= code_valid_next;
            entry_error <= entry_error_next;
            timeout     <= timeout_next;
            idle_cnt    <= idle_cnt_next;
        end
    end

    always_comb begin
        state_next       = state;
        entry_buf_next   = entry_buf;
        count_next       = digit_count;
        code_next        = in_code;
        code_valid_next  = 1'b0;
        entry_error_next = 1'b0;
        timeout_next     = 1'b0;
        idle_cnt_next    = (state == IDLE) ? '0 : idle_cnt + IW'(1);

        // A key arriving on the expiry cycle takes priority over the timeout.
        if (key_accepted) begin
            idle_cnt_next = '0;
            if (key_code == KEY_CLEAR) begin
                state_next     = IDLE;
                entry_buf_next = '0;
                count_next     = '0;
            end else if (key_code == KEY_ENTER) begin
                if (state == FULL) begin
                    code_next       = entry_buf;
                    code_valid_next = 1'b1;
                end else if (state == COLLECT) begin
                    entry_error_next = 1'b1;
                end
                state_next     = IDLE;
                entry_buf_next = '0;
                count_next     = '0;
            end else if (key_code <= 4'd9) begin
                if (state == FULL) begin
                    entry_error_next = 1'b1;
                end else begin
                    entry_buf_next = (entry_buf << 4) | CW'(key_code);
                    count_next     = digit_count + 3'd1;
                    state_next     = (count_next == 3'(NUM_DIGITS)) ? FULL : COLLECT;
                end
            end else begin
                entry_error_next = 1'b1;
            end
        end else if (idle_expired) begin
            state_next     = IDLE;
            entry_buf_next = '0;
            count_next     = '0;
            timeout_next   = 1'b1;
            idle_cnt_next  = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_code_entry.sv
`default_nettype none
// Testbench for keypad_code_entry: directed vector table, corner sequences and
// randomized keypresses compared against a queue-based reference model.
module tb_keypad_code_entry;

    localparam int ND = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        entry_en = 1'b1;
    logic [15:0] in_code;
    logic        code_valid;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    keypad_code_entry #(
        .NUM_DIGITS    (ND),
        .TIMEOUT_CYCLES(TO),
        .KEY_CLEAR     (4'hA),
        .KEY_ENTER     (4'hB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .entry_en   (entry_en),
        .in_code    (in_code),
        .code_valid (code_valid),
        .digit_count(digit_count),
        .entry_error(entry_error),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits as a queue, quiet-cycle counter
    int          digits[$];
    int          quiet;
    logic [15:0] m_code;
    bit          m_cv, m_err, m_to;

    function automatic void model_reset();
        digits.delete();
        quiet  = 0;
        m_code = '0;
        m_cv   = 0;
        m_err  = 0;
        m_to   = 0;
    endfunction

    function automatic logic [15:0] model_pack();
        int v = 0;
        foreach (digits[i]) v = v * 16 + digits[i];
        return 16'(v);
    endfunction

    function automatic void model_step(bit kv, logic [3:0] kc, bit en);
        m_cv  = 0;
        m_err = 0;
        m_to  = 0;
        if (kv && en) begin
            quiet = 0;
            if (kc == 4'hA) begin
                digits.delete();
            end else if (kc == 4'hB) begin
                if (digits.size() == ND) begin
                    m_code = model_pack();
                    m_cv   = 1;
                end else if (digits.size() > 0) begin
                    m_err = 1;
                end
                digits.delete();
            end else if (kc <= 4'd9) begin
                if (digits.size() == ND) m_err = 1;
                else digits.push_back(int'(kc));
            end else begin
                m_err = 1;
            end
        end else if (digits.size() > 0) begin
            quiet++;
            if (quiet == TO) begin
                digits.delete();
                m_to  = 1;
                quiet = 0;
            end
        end else begin
            quiet = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, step the model at the edge, check just after it.
    task automatic cycle(input bit kv, input logic [3:0] kc, input bit en);
        key_valid = kv;
        key_code  = kc;
        entry_en  = en;
        @(posedge clk);
        model_step(kv, kc, en);
        #1;
        chk("model_count", 32'(digit_count), 32'(digits.size()));
        chk("model_code", 32'(in_code), 32'(m_code));
        chk("model_code_valid", 32'(code_valid), 32'(m_cv));
        chk("model_entry_error", 32'(entry_error), 32'(m_err));
        chk("model_timeout", 32'(timeout), 32'(m_to));
    endtask

    typedef struct {
        bit          kv;
        logic [3:0]  kc;
        bit          en;
        int          cnt;
        logic [15:0] code;
        bit          cv, err, to;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input bit kv, input logic [3:0] kc, input bit en, input int cnt,
                        input logic [15:0] code, input bit cv, input bit err, input bit to);
        vec_t v;
        v.kv = kv; v.kc = kc; v.en = en; v.cnt = cnt;
        v.code = code; v.cv = cv; v.err = err; v.to = to;
        tbl.push_back(v);
    endtask

    initial begin
        int cv_seen;
        int density;

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_count", 32'(digit_count), 32'd0);
        chk("reset_code", 32'(in_code), 32'd0);
        chk("reset_pulses", 32'({code_valid, entry_error, timeout}), 32'd0);
        reset_n = 1'b1;

        // 1,4,7,3,ENTER
        addv(1,4'h1,1, 1,16'h0000,0,0,0); addv(0,4'h0,1, 1,16'h0000,0,0,0);
        addv(1,4'h4,1, 2,16'h0000,0,0,0); addv(0,4'h0,1, 2,16'h0000,0,0,0);
        addv(1,4'h7,1, 3,16'h0000,0,0,0); addv(0,4'h0,1, 3,16'h0000,0,0,0);
        addv(1,4'h3,1, 4,16'h0000,0,0,0); addv(0,4'h0,1, 4,16'h0000,0,0,0);
        addv(1,4'hB,1, 0,16'h1473,1,0,0); addv(0,4'h0,1, 0,16'h1473,0,0,0);
        // 1,2,ENTER: short entry rejected
        addv(1,4'h1,1, 1,16'h1473,0,0,0); addv(0,4'h0,1, 1,16'h1473,0,0,0);
        addv(1,4'h2,1, 2,16'h1473,0,0,0); addv(0,4'h0,1, 2,16'h1473,0,0,0);
        addv(1,4'hB,1, 0,16'h1473,0,1,0); addv(0,4'h0,1, 0,16'h1473,0,0,0);
        // 1,4,7,3,9,ENTER: fifth digit rejected
        addv(1,4'h1,1, 1,16'h1473,0,0,0); addv(0,4'h0,1, 1,16'h1473,0,0,0);
        addv(1,4'h4,1, 2,16'h1473,0,0,0); addv(0,4'h0,1, 2,16'h1473,0,0,0);
        addv(1,4'h7,1, 3,16'h1473,0,0,0); addv(0,4'h0,1, 3,16'h1473,0,0,0);
        addv(1,4'h3,1, 4,16'h1473,0,0,0); addv(0,4'h0,1, 4,16'h1473,0,0,0);
        addv(1,4'h9,1, 4,16'h1473,0,1,0); addv(0,4'h0,1, 4,16'h1473,0,0,0);
        addv(1,4'hB,1, 0,16'h1473,1,0,0); addv(0,4'h0,1, 0,16'h1473,0,0,0);
        // 1,4,invalid E,CLEAR, then disabled keys
        addv(1,4'h1,1, 1,16'h1473,0,0,0); addv(0,4'h0,1, 1,16'h1473,0,0,0);
        addv(1,4'h4,1, 2,16'h1473,0,0,0); addv(0,4'h0,1, 2,16'h1473,0,0,0);
        addv(1,4'hE,1, 2,16'h1473,0,1,0); addv(0,4'h0,1, 2,16'h1473,0,0,0);
        addv(1,4'hA,1, 0,16'h1473,0,0,0); addv(0,4'h0,1, 0,16'h1473,0,0,0);
        addv(1,4'h5,0, 0,16'h1473,0,0,0); addv(1,4'h5,0, 0,16'h1473,0,0,0);
        addv(1,4'h5,0, 0,16'h1473,0,0,0); addv(1,4'h5,0, 0,16'h1473,0,0,0);
        addv(1,4'hB,0, 0,16'h1473,0,0,0); addv(0,4'h0,1, 0,16'h1473,0,0,0);

        foreach (tbl[i]) begin
            cycle(tbl[i].kv, tbl[i].kc, tbl[i].en);
            chk($sformatf("vec%0d_count", i), 32'(digit_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_code", i), 32'(in_code), 32'(tbl[i].code));
            chk($sformatf("vec%0d_pulses", i), 32'({code_valid, entry_error, timeout}),
                32'({tbl[i].cv, tbl[i].err, tbl[i].to}));
        end

        // Inactivity timeout after 2,1
        cycle(1, 4'h2, 1);
        cycle(1, 4'h1, 1);
        for (int i = 1; i <= TO; i++) begin
            cycle(0, 4'h0, 1);
            chk("timeout_pulse", 32'(timeout), (i == TO) ? 32'd1 : 32'd0);
            chk("timeout_count", 32'(digit_count), (i == TO) ? 32'd0 : 32'd2);
        end
        cycle(1, 4'h4, 1); cycle(1, 4'h6, 1); cycle(1, 4'h6, 1); cycle(1, 4'h7, 1);
        cycle(1, 4'hB, 1);
        chk("after_timeout_code", 32'(in_code), 32'h4667);
        chk("after_timeout_cv", 32'(code_valid), 32'd1);

        // Key on the expiry cycle wins over the timeout
        cycle(1, 4'h5, 1);
        repeat (TO - 1) cycle(0, 4'h0, 1);
        cycle(1, 4'h3, 1);
        chk("race_no_timeout", 32'(timeout), 32'd0);
        chk("race_count", 32'(digit_count), 32'd2);
        repeat (TO) cycle(0, 4'h0, 1);
        chk("race_late_timeout", 32'(timeout), 32'd1);

        // Reset in the middle of an entry
        cycle(1, 4'h1, 1); cycle(1, 4'h4, 1); cycle(1, 4'h7, 1);
        key_valid = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_count", 32'(digit_count), 32'd0);
        chk("midreset_code", 32'(in_code), 32'd0);
        @(posedge clk); #1;
        chk("midreset_pulses", 32'({code_valid, entry_error, timeout}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cv_seen = 0;
        cycle(1, 4'h1, 1); cv_seen += int'(code_valid);
        cycle(1, 4'h4, 1); cv_seen += int'(code_valid);
        cycle(1, 4'h7, 1); cv_seen += int'(code_valid);
        cycle(1, 4'h3, 1); cv_seen += int'(code_valid);
        cycle(1, 4'hB, 1); cv_seen += int'(code_valid);
        cycle(0, 4'h0, 1); cv_seen += int'(code_valid);
        chk("postreset_code", 32'(in_code), 32'h1473);
        chk("postreset_cv_count", 32'(cv_seen), 32'd1);

        // Randomized traffic with varying key density so timeouts also occur
        density = 1;
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [3:0] kc;
            if (n % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: density = 1;
                    1: density = 2;
                    2: density = 4;
                    default: density = 12;
                endcase
            end
            r = $urandom_range(0, 19);
            if (r < 12)      kc = 4'($urandom_range(0, 9));
            else if (r < 15) kc = 4'hB;
            else if (r < 17) kc = 4'hA;
            else             kc = 4'($urandom_range(12, 15));
            cycle($urandom_range(0, density - 1) == 0, kc, $urandom_range(0, 9) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
Keypad-side front end for the combination lock. It collects BCD digit keypresses, assembles them into a NUM_DIGITS-digit packed BCD code, and presents the code to the lock's in_code input with a one-cycle submit strobe. It handles clear, enter, invalid keys and an inactivity timeout, so the lock sees only complete, deliberate code submissions.

Parameters:
NUM_DIGITS, 4, digits per code; code width CW = 4*NUM_DIGITS (16 by default).
TIMEOUT_CYCLES, 1000, idle cycles mid-entry before the partial entry is discarded; must be >= 2.
KEY_CLEAR, 4'hA, key code that discards the current entry.
KEY_ENTER, 4'hB, key code that submits the current entry.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
key_valid  input  1  one-cycle strobe; key_code is sampled when high.
key_code  input  4  0-9 digit, KEY_CLEAR, KEY_ENTER; any other value is invalid.
entry_en  input  1  when low, keypresses are ignored silently (lock busy/lockout).
in_code  output  CW  last submitted code, packed BCD, most significant digit first entered; held stable between submits.
code_valid  output  1  one-cycle pulse when in_code is updated by a submit.
digit_count  output  3  digits currently buffered (0..NUM_DIGITS).
entry_error  output  1  one-cycle pulse on a rejected key (see below).
timeout  output  1  one-cycle pulse when a partial entry is discarded by inactivity.

Behaviour:
- Reset (reset_n low, async): state IDLE, shift buffer 0, in_code 0, digit_count 0, code_valid/entry_error/timeout 0, idle counter 0.
- All outputs registered; a key sampled at edge N produces its effects visible after edge N (1-cycle latency).
- States: IDLE (count 0), COLLECT (0 < count < NUM_DIGITS), FULL (count = NUM_DIGITS).
- Digit key (0-9): in IDLE/COLLECT buf <= {buf[CW-5:0], digit}, count++; reaching NUM_DIGITS -> FULL, else COLLECT. In FULL: digit ignored, buffer unchanged, entry_error pulse.
- KEY_ENTER: in FULL -> in_code <= buf, code_valid pulse, buf/count cleared, -> IDLE. In COLLECT -> entry_error pulse, buf/count cleared, -> IDLE, in_code unchanged. In IDLE -> ignored, no error.
- KEY_CLEAR: any state -> buf/count cleared, -> IDLE, no pulses.
- Invalid key (4'hC-4'hF or other non-defined): entry_error pulse, state/buffer unchanged.
- entry_en low: key_valid ignored entirely (no state change, no pulses); idle counter keeps running; buffered digits are preserved.
- Idle counter: counts clk cycles in COLLECT/FULL, resets to 0 on any accepted key_valid and in IDLE. When it reaches TIMEOUT_CYCLES-1 without a key -> buf/count cleared, -> IDLE, timeout pulse.
- Simultaneous key_valid and timeout expiry: the key wins; the counter restarts and the key is processed normally; no timeout pulse.
- Pulses never overlap: at most one of code_valid/entry_error/timeout per cycle.
- Reset mid-entry: everything returns to reset values immediately; no code_valid is emitted.
- Same code submitted twice: code_valid pulses each time even if in_code is unchanged.

Test Plan:
- Keys 1,4,7,3,ENTER (one per 2 cycles) -> digit_count 1,2,3,4,0; in_code = 16'h1473, code_valid high exactly 1 cycle after the ENTER edge.
- Keys 1,2,ENTER -> entry_error 1-cycle pulse, digit_count 0, in_code keeps its prior value (16'h1473), no code_valid.
- Keys 1,4,7,3,9,ENTER -> 9 gives an entry_error pulse, then in_code = 16'h1473 with code_valid.
- Keys 2,1 then idle for TIMEOUT_CYCLES (set 8) -> timeout pulse at cycle 8, digit_count 0; then 4,6,6,7,ENTER -> in_code = 16'h4667.
- Keys 1,4, then KEY 4'hE -> entry_error and digit_count stays 2; then CLEAR -> count 0; then entry_en=0 with 5,5,5,5,ENTER -> no change, no pulses.
- Keys 1,4,7 then reset_n low for 1 cycle mid-entry -> all outputs 0; keys 1,4,7,3,ENTER -> in_code 16'h1473 with a single code_valid pulse.
